// File: rtl/alu_fpga_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : alu_fpga_pkg
//  Description : Board-harness types: FSM states, seven-segment tables and
//                the nibble-to-segment decoder (active-low segments).
//  Revision    : 1.0  initial release
// ============================================================================
package alu_fpga_pkg;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is 0
    localparam logic [6:0] SEG_HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    localparam logic [6:0] SEG_DASH = 7'b0111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] i_nib);
        return SEG_HEX[i_nib];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_types_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cpu_types_pkg
//  Description : Shared CPU-wide types. aluop_t is the alu opcode encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_types_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9
    } aluop_t;

endpackage
`default_nettype wire

// File: rtl/alu_fpga_ctrl_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : key_debounce
//  Description : Two-flop synchroniser plus stability counter for one
//                active-low push button. Emits a single-cycle pulse on each
//                accepted press (accepted 1->0 transition of the level).
//  Revision    : 1.0  initial release
// ============================================================================
module key_debounce #(
    parameter int DEBOUNCE_CYC = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_press
);

    localparam int             CW         = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0]  c_last_cnt = CW'(DEBOUNCE_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_level;
    logic          r_press;
    logic [CW-1:0] r_cnt;

    // Bring the raw key into the clock domain; released (1) out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level after DEBOUNCE_CYC consecutive cycles of disagreement;
    // any return to the accepted level restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_press <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_last_cnt) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
                r_press <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/alu_fpga_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_fpga_ctrl
//  Description : Board harness for the 32-bit alu. Debounced keys step an
//                FSM through operand A, operand B and opcode entry, execute,
//                then show the registered result and flags on HEX/LEDR.
//                Optional result history: define ALU_RESULT_HIST_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_fpga_ctrl
    import cpu_types_pkg::*;
    import alu_fpga_pkg::*;
#(
    parameter int IMM_W        = 16,
    parameter int DIGITS       = 8,
    parameter int DEBOUNCE_CYC = 250000,
    parameter int HIST_DEPTH   = 4
) (
    input  logic                   CLOCK_50,
    input  logic                   nRST,
    input  logic [3:0]             KEY,
    input  logic [17:0]            SW,
    output logic [DIGITS-1:0][6:0] HEX,
    output logic [8:0]             LEDG,
    output logic [2:0]             LEDR
);

    localparam int c_ext = 32 - (IMM_W + 1);

    state_t      r_state, w_next;
    logic [31:0] r_a, r_b, r_result;
    aluop_t      r_op;
    logic [2:0]  r_flags;            // {negative, overflow, zero}

    logic        w_enter, w_clear;
    logic        w_lat_a, w_lat_b, w_lat_op, w_do_clear;
    logic [31:0] w_sext, w_sum, w_diff, w_alu_y, w_show, w_hist_word;
    logic        w_alu_v, w_view;
    logic        w_unused;

    assign w_sext = {{c_ext{SW[IMM_W]}}, SW[IMM_W:0]};

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_enter (
        .clk(CLOCK_50), .rst_n(nRST), .i_key_n(KEY[0]), .o_press(w_enter));
    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_clear (
        .clk(CLOCK_50), .rst_n(nRST), .i_key_n(KEY[3]), .o_press(w_clear));

    // FSM state register
    always_ff @(posedge CLOCK_50 or negedge nRST) begin
        if (!nRST) r_state <= S_A;
        else       r_state <= w_next;
    end

    // Next state and latch strobes; clear overrides enter in every state
    always_comb begin
        w_next     = r_state;
        w_lat_a    = 1'b0;
        w_lat_b    = 1'b0;
        w_lat_op   = 1'b0;
        w_do_clear = 1'b0;
        if (w_clear) begin
            w_next     = S_A;
            w_do_clear = 1'b1;
        end else begin
            case (r_state)
                S_A:    if (w_enter) begin w_next = S_B;    w_lat_a  = 1'b1; end
                S_B:    if (w_enter) begin w_next = S_OP;   w_lat_b  = 1'b1; end
                S_OP:   if (w_enter) begin w_next = S_EXEC; w_lat_op = 1'b1; end
                S_EXEC: w_next = S_SHOW;
                S_SHOW: if (w_enter) w_next = S_A;
                default: w_next = S_A;
            endcase
        end
    end

    // Operand / opcode registers; result and flags capture the alu in S_EXEC
    always_ff @(posedge CLOCK_50 or negedge nRST) begin
        if (!nRST) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= ALU_ADD;
            r_result <= '0;
            r_flags  <= '0;
        end else begin
            if (w_do_clear) begin
                r_a  <= '0;
                r_b  <= '0;
                r_op <= ALU_ADD;
            end else begin
                if (w_lat_a)  r_a  <= w_sext;
                if (w_lat_b)  r_b  <= w_sext;
                if (w_lat_op) r_op <= aluop_t'(SW[3:0]);
            end
            if (r_state == S_EXEC) begin
                r_result <= w_alu_y;
                r_flags  <= {w_alu_y[31], w_alu_v, (w_alu_y == 32'd0)};
            end
        end
    end

    assign w_sum  = r_a + r_b;
    assign w_diff = r_a - r_b;

    // ALU datapath; overflow is meaningful only for signed add/sub
    always_comb begin
        w_alu_y = '0;
        w_alu_v = 1'b0;
        case (r_op)
            ALU_ADD: begin
                w_alu_y = w_sum;
                w_alu_v = (r_a[31] == r_b[31]) && (w_sum[31] != r_a[31]);
            end
            ALU_SUB: begin
                w_alu_y = w_diff;
                w_alu_v = (r_a[31] != r_b[31]) && (w_diff[31] != r_a[31]);
            end
            ALU_AND:  w_alu_y = r_a & r_b;
            ALU_OR:   w_alu_y = r_a | r_b;
            ALU_XOR:  w_alu_y = r_a ^ r_b;
            ALU_SLL:  w_alu_y = r_a << r_b[4:0];
            ALU_SRL:  w_alu_y = r_a >> r_b[4:0];
            ALU_SRA:  w_alu_y = $signed(r_a) >>> r_b[4:0];
            ALU_SLT:  w_alu_y = {31'd0, $signed(r_a) < $signed(r_b)};
            ALU_SLTU: w_alu_y = {31'd0, r_a < r_b};
            default:  w_alu_y = '0;
        endcase
    end

`ifdef ALU_RESULT_HIST_EN
    localparam int HW = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

    logic [31:0]   r_hist [HIST_DEPTH];
    logic [HW-1:0] r_wptr, r_vidx;
    logic          r_view;
    logic          w_hstep;

    key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_key_hist (
        .clk(CLOCK_50), .rst_n(nRST), .i_key_n(KEY[1]), .o_press(w_hstep));

    // Circular result buffer, one write per execution
    always_ff @(posedge CLOCK_50 or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < HIST_DEPTH; i++) r_hist[i] <= '0;
            r_wptr <= '0;
        end else if (r_state == S_EXEC) begin
            r_hist[r_wptr] <= w_alu_y;
            r_wptr         <= r_wptr + 1'b1;
        end
    end

    // View mode: first step shows newest, later steps walk older and wrap
    always_ff @(posedge CLOCK_50 or negedge nRST) begin
        if (!nRST) begin
            r_view <= 1'b0;
            r_vidx <= '0;
        end else if (w_next != S_SHOW) begin
            r_view <= 1'b0;
            r_vidx <= '0;
        end else if (r_state == S_SHOW && w_hstep) begin
            if (!r_view) begin
                r_view <= 1'b1;
                r_vidx <= '0;
            end else begin
                r_vidx <= r_vidx + 1'b1;
            end
        end
    end

    assign w_view      = r_view;
    assign w_hist_word = r_hist[r_wptr - HW'(1) - r_vidx];
    assign LEDG[7:5]   = 3'(r_vidx);
    assign LEDG[8]     = r_view;
    assign w_unused    = ^{KEY[2], SW[17]};
`else
    assign w_view      = 1'b0;
    assign w_hist_word = '0;
    assign LEDG[8:5]   = 4'd0;
    assign w_unused    = ^{KEY[2], KEY[1], SW[17], HIST_DEPTH[3:0]};
`endif

    // Word shown on the displays: live switches during entry, result afterwards
    always_comb begin
        w_show = w_sext;
        case (r_state)
            S_EXEC, S_SHOW: w_show = w_view ? w_hist_word : r_result;
            default:        w_show = w_sext;
        endcase
    end

    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_hex
        assign HEX[gi] = (r_state == S_OP) ? ((gi == 0) ? seg_decode(SW[3:0]) : SEG_DASH)
                                           : seg_decode(w_show[4*gi +: 4]);
    end

    assign LEDG[4:0] = 5'b00001 << r_state;
    assign LEDR      = (r_state == S_SHOW) ? r_flags : 3'b000;

endmodule
`default_nettype wire

// File: tb/tb_alu_fpga_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_fpga_ctrl
//  Description : Self-checking bench for alu_fpga_ctrl with a behavioural
//                model of the alu, the display and the result history.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_fpga_ctrl;

    localparam logic [4:0] ST_A    = 5'b00001;
    localparam logic [4:0] ST_B    = 5'b00010;
    localparam logic [4:0] ST_OP   = 5'b00100;
    localparam logic [4:0] ST_EXEC = 5'b01000;
    localparam logic [4:0] ST_SHOW = 5'b10000;
    localparam longint LMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint LMIN = -64'sh0000_0000_8000_0000;
    localparam int     HDEPTH = 4;

    localparam logic [6:0] SEG_T [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic            CLOCK_50 = 1'b0;
    logic            nRST;
    logic [3:0]      KEY;
    logic [17:0]     SW;
    logic [7:0][6:0] HEX;
    logic [8:0]      LEDG;
    logic [2:0]      LEDR;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] prev_result;
    logic [31:0] hist_q [$];

    alu_fpga_ctrl #(.IMM_W(16), .DIGITS(8), .DEBOUNCE_CYC(4), .HIST_DEPTH(HDEPTH)) dut (
        .CLOCK_50(CLOCK_50), .nRST(nRST), .KEY(KEY), .SW(SW),
        .HEX(HEX), .LEDG(LEDG), .LEDR(LEDR));

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [31:0] sext17(input logic [16:0] v);
        return 32'($signed(v));
    endfunction

    function automatic logic [7:0][6:0] hex_of(input logic [31:0] w);
        logic [7:0][6:0] h;
        for (int i = 0; i < 8; i++) h[i] = SEG_T[w[4*i +: 4]];
        return h;
    endfunction

    // Returns {negative, overflow, zero, result}
    function automatic logic [34:0] model_alu(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        logic [31:0] y;
        bit          v;
        longint      s;
        y = 0;
        v = 0;
        case (op)
            4'd0: begin s = longint'($signed(a)) + longint'($signed(b)); y = s[31:0]; v = (s > LMAX) || (s < LMIN); end
            4'd1: begin s = longint'($signed(a)) - longint'($signed(b)); y = s[31:0]; v = (s > LMAX) || (s < LMIN); end
            4'd2: y = a & b;
            4'd3: y = a | b;
            4'd4: y = a ^ b;
            4'd5: y = a << b[4:0];
            4'd6: y = a >> b[4:0];
            4'd7: y = 32'($signed(a) >>> b[4:0]);
            4'd8: y = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9: y = (a < b) ? 32'd1 : 32'd0;
            default: y = 0;
        endcase
        return {y[31], v, (y == 0), y};
    endfunction

    function automatic logic [31:0] hist_entry(input int idx);
        if (idx < hist_q.size()) return hist_q[hist_q.size() - 1 - idx];
        return 32'd0;
    endfunction

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic press_key(input int idx);
        KEY[idx] = 1'b0;
        wait_cyc(10);
        KEY[idx] = 1'b1;
        wait_cyc(10);
    endtask

    // Enter A, B and op from S_A; ends in S_SHOW with the model updated
    task automatic run_seq(input logic [16:0] a, input logic [16:0] b, input logic [3:0] op,
                           input string tag);
        logic [34:0] m;
        bit          seen;
        int          exec_cyc;
        m = model_alu(sext17(a), sext17(b), op);
        n_checks++;
        if (LEDG[4:0] !== ST_A) begin n_fail++; $display("FAIL %s start_state: got %b want %b", tag, LEDG[4:0], ST_A); end
        SW = {1'b0, a};
        press_key(0);
        SW = {1'b0, b};
        press_key(0);
        n_checks++;
        if (LEDG[4:0] !== ST_OP || HEX[7:1] !== {7{7'b0111111}}) begin
            n_fail++; $display("FAIL %s op_state: state %b hex %h", tag, LEDG[4:0], HEX);
        end
        SW = {14'd0, op};
        KEY[0] = 1'b0;
        seen = 0;
        exec_cyc = 0;
        for (int c = 1; c <= 14 && !seen; c++) begin
            @(negedge CLOCK_50);
            if (LEDG[4:0] === ST_EXEC) begin seen = 1; exec_cyc = c; end
        end
        n_checks++;
        if (!seen || exec_cyc != 7) begin
            n_fail++; $display("FAIL %s exec_timing: seen %0d cycle %0d want 7", tag, seen, exec_cyc);
        end
        if (seen) begin
            n_checks++;
            if (HEX !== hex_of(prev_result)) begin
                n_fail++; $display("FAIL %s exec_shows_prev: got %h want %h", tag, HEX, hex_of(prev_result));
            end
            @(negedge CLOCK_50);
            n_checks++;
            if (LEDG[4:0] !== ST_SHOW || HEX !== hex_of(m[31:0]) || LEDR !== m[34:32]) begin
                n_fail++;
                $display("FAIL %s show: state %b hex %h ledr %b want hex %h ledr %b (y=%h)",
                         tag, LEDG[4:0], HEX, LEDR, hex_of(m[31:0]), m[34:32], m[31:0]);
            end
        end
        KEY[0] = 1'b1;
        wait_cyc(10);
        prev_result = m[31:0];
        hist_q.push_back(m[31:0]);
        if (hist_q.size() > HDEPTH) void'(hist_q.pop_front());
    endtask

    task automatic leave_show(input string tag);
        press_key(0);
        n_checks++;
        if (LEDG !== 9'h001 || LEDR !== 3'b000) begin
            n_fail++; $display("FAIL %s leave_show: ledg %b ledr %b want ledg 000000001 ledr 000", tag, LEDG, LEDR);
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        KEY  = 4'hF;
        SW   = 18'h00005;
        prev_result = 0;
        hist_q.delete();
        wait_cyc(3);
        nRST = 1'b1;
        wait_cyc(5);
        n_checks++;
        if (LEDG !== 9'h001) begin n_fail++; $display("FAIL reset_ledg: got %b want 000000001", LEDG); end
        n_checks++;
        if (LEDR !== 3'b000) begin n_fail++; $display("FAIL reset_ledr: got %b want 000", LEDR); end
        n_checks++;
        if (HEX[0] !== 7'b0010010 || HEX !== hex_of(32'h5)) begin
            n_fail++; $display("FAIL reset_hex: got %h want %h", HEX, hex_of(32'h5));
        end
    endtask

    task automatic test_live_display();
        logic [16:0] v;
        for (int i = 0; i < 4; i++) begin
            v = 17'($urandom);
            SW = {1'b0, v};
            wait_cyc(1);
            n_checks++;
            if (HEX !== hex_of(sext17(v))) begin
                n_fail++; $display("FAIL live_display[%0d]: sw %h got %h want %h", i, v, HEX, hex_of(sext17(v)));
            end
        end
    endtask

    task automatic test_bounce();
        bit moved_early;
        moved_early = 0;
        for (int t = 0; t < 10; t++) begin
            KEY[0] = ~KEY[0];
            repeat (2) begin
                @(negedge CLOCK_50);
                if (LEDG[4:0] !== ST_A) moved_early = 1;
            end
        end
        KEY[0] = 1'b0;
        n_checks++;
        if (moved_early) begin n_fail++; $display("FAIL bounce_no_early: state left S_A while bouncing"); end
        wait_cyc(6);
        n_checks++;
        if (LEDG[4:0] !== ST_A) begin n_fail++; $display("FAIL bounce_before_accept: got %b want %b", LEDG[4:0], ST_A); end
        wait_cyc(1);
        n_checks++;
        if (LEDG[4:0] !== ST_B) begin n_fail++; $display("FAIL bounce_accept: got %b want %b", LEDG[4:0], ST_B); end
        wait_cyc(20);
        n_checks++;
        if (LEDG[4:0] !== ST_B) begin n_fail++; $display("FAIL bounce_single_pulse: got %b want %b", LEDG[4:0], ST_B); end
        KEY[0] = 1'b1;
        wait_cyc(10);
        press_key(3);
        n_checks++;
        if (LEDG[4:0] !== ST_A) begin n_fail++; $display("FAIL bounce_clear: got %b want %b", LEDG[4:0], ST_A); end
    endtask

    task automatic test_directed();
        run_seq(17'h1FFFF, 17'h00001, 4'd0, "add_m1_p1");
        leave_show("add_m1_p1");
        run_seq(17'h18000, 17'h00001, 4'd1, "sub_8000");
        leave_show("sub_8000");
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            run_seq(17'($urandom), 17'($urandom), 4'($urandom_range(0, 9)), $sformatf("rand%0d", i));
            leave_show("rand");
        end
    endtask

    task automatic test_clear_enter();
        SW = 18'h00123;
        press_key(0);
        SW = 18'h00045;
        press_key(0);
        KEY[0] = 1'b0;
        KEY[3] = 1'b0;
        wait_cyc(10);
        n_checks++;
        if (LEDG[4:0] !== ST_A || LEDR !== 3'b000) begin
            n_fail++; $display("FAIL clear_wins: state %b ledr %b want %b 000", LEDG[4:0], LEDR, ST_A);
        end
        KEY = 4'hF;
        wait_cyc(10);
        n_checks++;
        if (LEDG[4:0] !== ST_A) begin n_fail++; $display("FAIL clear_release: got %b want %b", LEDG[4:0], ST_A); end
        // result untouched: the next S_EXEC cycle still shows it
        run_seq(17'h00002, 17'h00003, 4'd0, "after_clear");
        leave_show("after_clear");
    endtask

    task automatic test_async_reset();
        run_seq(17'h00000, 17'h00001, 4'd1, "pre_reset");
        KEY[0] = 1'b0;
        wait_cyc(3);
        #2;
        nRST = 1'b0;
        #1;
        n_checks++;
        if (LEDG !== 9'h001 || LEDR !== 3'b000 || HEX !== hex_of(sext17(SW[16:0]))) begin
            n_fail++; $display("FAIL async_reset: ledg %b ledr %b hex %h want 000000001 000 %h",
                               LEDG, LEDR, HEX, hex_of(sext17(SW[16:0])));
        end
        KEY[0] = 1'b1;
        prev_result = 0;
        hist_q.delete();
        wait_cyc(2);
        nRST = 1'b1;
        wait_cyc(10);
        n_checks++;
        if (LEDG !== 9'h001) begin n_fail++; $display("FAIL async_reset_settle: got %b want 000000001", LEDG); end
        run_seq(17'h00007, 17'h00001, 4'd2, "post_reset");
        leave_show("post_reset");
    endtask

    task automatic test_history();
        for (int k = 1; k <= 5; k++) begin
            run_seq(17'(k), 17'd0, 4'd0, $sformatf("hist_exec%0d", k));
            if (k < 5) leave_show("hist_exec");
        end
`ifdef ALU_RESULT_HIST_EN
        for (int p = 0; p < 5; p++) begin
            press_key(1);
            n_checks++;
            if (HEX !== hex_of(hist_entry(p % HDEPTH)) || LEDG[8] !== 1'b1 || LEDG[7:5] !== 3'(p % HDEPTH)) begin
                n_fail++; $display("FAIL hist_view[%0d]: hex %h ledg %b want hex %h idx %0d",
                                   p, HEX, LEDG, hex_of(hist_entry(p % HDEPTH)), p % HDEPTH);
            end
        end
`else
        press_key(1);
        n_checks++;
        if (HEX !== hex_of(prev_result) || LEDG[8:5] !== 4'd0 || LEDG[4:0] !== ST_SHOW) begin
            n_fail++; $display("FAIL hist_ignored: hex %h ledg %b want hex %h", HEX, LEDG, hex_of(prev_result));
        end
`endif
        leave_show("hist_exit");
    endtask

    initial begin
        test_reset();
        test_live_display();
        test_bounce();
        test_directed();
        test_random();
        test_clear_enter();
        test_async_reset();
        test_history();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
